// File: rtl/mult_seq_ctrl.sv
// Sequential shift-add unsigned multiplier controller.
// Drives an external adder one partial product per cycle; WIDTH+1 cycle latency.
module mult_seq_ctrl #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_ci,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_co
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] mcand;
    logic             run;

    assign run    = (state == RUN);
    assign add_a  = run ? hi : '0;
    assign add_b  = (run && lo[0]) ? mcand : '0;
    assign add_ci = 1'b0;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            mcand <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        hi    <= '0;
                        lo    <= op_b;
                        mcand <= op_a;
                        cnt   <= '0;
                        state <= RUN;
                        busy  <= 1'b1;
                    end
                end
                RUN: begin
                    if (abort) begin
                        hi    <= '0;
                        lo    <= '0;
                        cnt   <= '0;
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        // Carry-out lands in hi MSB so the product is never truncated
                        hi <= {add_co, add_s[WIDTH-1:1]};
                        lo <= {add_s[0], lo[WIDTH-1:1]};
                        if (cnt == LAST) begin
                            cnt   <= '0;
                            state <= DONE;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end else begin
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                    done  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mult_seq_ctrl.sv
// Scoreboard bench for mult_seq_ctrl with a behavioural external adder.
// Expected products are hand-computed constants queued at issue time.
module tb_mult_seq_ctrl;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic         abort = 1'b0;
    logic [W-1:0] op_a = '0;
    logic [W-1:0] op_b = '0;
    logic         busy;
    logic         done;
    logic [W-1:0] hi;
    logic [W-1:0] lo;
    logic [W-1:0] add_a;
    logic [W-1:0] add_b;
    logic         add_ci;
    logic [W-1:0] add_s;
    logic         add_co;

    int vectors = 0;
    int miscompares = 0;
    logic [2*W-1:0] sb_q[$];

    always #5 clk = ~clk;

    assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {{W{1'b0}}, add_ci};

    mult_seq_ctrl #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .op_a(op_a), .op_b(op_b), .busy(busy), .done(done),
        .hi(hi), .lo(lo), .add_a(add_a), .add_b(add_b),
        .add_ci(add_ci), .add_s(add_s), .add_co(add_co)
    );

    task automatic check(input string name, input logic [63:0] act,
                         input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every done pulse must match the oldest queued product
    always @(negedge clk) begin
        if (done) begin
            if (sb_q.size() == 0) begin
                check("unexpected_done", 64'(done), 64'(0));
            end else begin
                logic [2*W-1:0] e;
                e = sb_q.pop_front();
                check("prod_hi", 64'(hi), 64'(e[2*W-1:W]));
                check("prod_lo", 64'(lo), 64'(e[W-1:0]));
                check("busy_with_done", 64'(busy), 64'(0));
            end
        end
    end

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b);
        @(negedge clk);
        op_a  = a;
        op_b  = b;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(output int nbusy);
        bit seen;
        seen  = 1'b0;
        nbusy = 0;
        for (int i = 0; i < 200; i++) begin
            if (done) begin
                seen = 1'b1;
                break;
            end
            if (busy) nbusy++;
            @(negedge clk);
        end
        if (!seen) check("done_timeout", 64'(0), 64'(1));
    endtask

    task automatic product(input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [2*W-1:0] exp);
        int nb;
        sb_q.push_back(exp);
        issue(a, b);
        wait_done(nb);
        check("busy_cycles", 64'(nb), 64'(32));
        @(negedge clk);
    endtask

    initial begin
        int nb;
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_hilo", {hi, lo}, 64'(0));
        check("rst_add_a", 64'(add_a), 64'(0));
        rst = 1'b0;

        product(32'd3, 32'd5, 64'h0000_0000_0000_000F);
        product(32'hFFFF_FFFF, 32'hFFFF_FFFF, 64'hFFFF_FFFE_0000_0001);
        product(32'h8000_0000, 32'd2, 64'h0000_0001_0000_0000);
        product(32'd0, 32'h1234_5678, 64'h0);
        product(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000);
        product(32'hFFFF_FFFF, 32'd2, 64'h0000_0001_FFFF_FFFE);

        repeat (3) @(negedge clk);
        check("idle_hold", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
        check("idle_add_b", 64'(add_b), 64'(0));

        // Second start mid-run plus operand change must be ignored
        sb_q.push_back(64'd20000);
        issue(32'd100, 32'd200);
        repeat (4) @(negedge clk);
        op_a  = 32'd7;
        op_b  = 32'd9;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wait_done(nb);
        op_a  = 32'd11;
        op_b  = 32'd13;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check("start_in_done", 64'(busy), 64'(0));
        @(negedge clk);
        check("start_in_done2", 64'(busy), 64'(0));

        // Abort at run cycle 10
        issue(32'd7, 32'd9);
        repeat (9) @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_busy", 64'(busy), 64'(0));
        check("abort_hilo", {hi, lo}, 64'(0));
        repeat (40) @(negedge clk);
        product(32'h1234_5678, 32'h10, 64'h0000_0001_2345_6780);

        // Abort outside RUN is harmless to the done pulse
        sb_q.push_back(64'd42);
        issue(32'd6, 32'd7);
        wait_done(nb);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        check("abort_in_done_hilo", {hi, lo}, 64'd42);

        // Reset mid-run with start held high
        issue(32'd11, 32'd13);
        repeat (19) @(negedge clk);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        check("midrst_busy", 64'(busy), 64'(0));
        check("midrst_done", 64'(done), 64'(0));
        check("midrst_hilo", {hi, lo}, 64'(0));
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("rst_start_drop", 64'(busy), 64'(0));
        product(32'd6, 32'd7, 64'd42);

        repeat (40) @(negedge clk);
        check("queue_empty", 64'(sb_q.size()), 64'(0));
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
